// File: rtl/ndata_compactor_pkg.sv
// libstf: shared types and helpers for the ndata compactor slice
package libstf;
  typedef logic [63:0] data64_t;
  typedef enum logic {PASS, FLUSH} compactor_state_t;
  function automatic int unsigned POPCOUNT(input logic [63:0] keep);
    int unsigned c = 0;
    for (int i = 0; i < 64; i++) c += 32'(keep[i]);
    return c;
  endfunction
  function automatic logic [63:0] LOW_MASK(input int unsigned n);
    return n >= 64 ? '1 : (64'd1 << n) - 64'd1;
  endfunction
  function automatic logic [31:0] SAT_ADD32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction
endpackage

// File: rtl/ndata_i.sv
// ndata_i: valid/ready ndata stream bundle with per-lane keep
interface ndata_i #(
  parameter int NUM_ELEMENTS = 8,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_ELEMENTS*DATA_WIDTH-1:0] data;
  logic [NUM_ELEMENTS-1:0] keep;
  logic last;
  logic valid;
  logic ready;
  modport s(input data, keep, last, valid, output ready);
  modport m(output data, keep, last, valid, input ready);
endinterface

// File: rtl/ndata_compact_lanes.sv
// ndata_compact_lanes: packs kept lanes densely from lane 0 via a running prefix count
module ndata_compact_lanes #(
  parameter int NUM_ELEMENTS = 8,
  parameter int DATA_WIDTH = 64,
  localparam int CW = $clog2(2*NUM_ELEMENTS)
) (
  input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0] data,
  input  logic [NUM_ELEMENTS-1:0] keep,
  output logic [NUM_ELEMENTS*DATA_WIDTH-1:0] dense,
  output logic [CW-1:0] cnt
);
  always_comb begin
    dense = '0;
    cnt = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      if (keep[i]) begin
        dense[32'(cnt)*DATA_WIDTH +: DATA_WIDTH] = data[i*DATA_WIDTH +: DATA_WIDTH];
        cnt = cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/ndata_compactor.sv
// ndata_compactor: compacts sparse-keep ndata beats into dense beats; stats counters under NDATA_COMPACTOR_STATS_EN
module ndata_compactor
  import libstf::*;
#(
  parameter int NUM_ELEMENTS = 8,
  parameter int DATA_WIDTH = 64
) (
  input logic clk,
  input logic rst,
  ndata_i.s in,
  ndata_i.m out
`ifdef NDATA_COMPACTOR_STATS_EN
  ,
  output logic [31:0] stat_elems_in,
  output logic [31:0] stat_elems_out,
  output logic [31:0] stat_streams
`endif
);
  localparam int N = NUM_ELEMENTS;
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(2*N);
  localparam int MW = (2*N-1)*W;
  localparam logic [CW-1:0] NL = CW'(N);
  logic [N*W-1:0] dense_data;
  logic [CW-1:0] cnt, fill, total, n_fill;
  logic [(N-1)*W-1:0] carry, n_carry;
  logic [MW-1:0] merged;
  compactor_state_t state, n_state;
  logic o_valid, o_last;
  logic [N-1:0] o_keep;
  logic [N*W-1:0] o_data;
  logic emit, e_last, in_fire, slot_free;
  logic [N-1:0] e_keep;
  logic [N*W-1:0] e_data;
  ndata_compact_lanes #(.NUM_ELEMENTS(N), .DATA_WIDTH(W)) u_lanes (
    .data(in.data),
    .keep(in.keep),
    .dense(dense_data),
    .cnt(cnt)
  );
  assign slot_free = !o_valid || out.ready;
  assign in.ready = (state == PASS) && slot_free;
  assign in_fire = in.valid && in.ready;
  assign total = fill + cnt;
  assign merged = (MW'(dense_data) << (32'(fill) * W)) | MW'(carry);
  assign out.valid = o_valid;
  assign out.data = o_data;
  assign out.keep = o_keep;
  assign out.last = o_last;
  always_comb begin
    emit = 1'b0;
    e_last = 1'b0;
    e_keep = '0;
    e_data = merged[N*W-1:0];
    n_fill = fill;
    n_carry = carry;
    n_state = state;
    if (state == FLUSH) begin
      if (slot_free) begin
        emit = 1'b1;
        e_last = 1'b1;
        e_keep = N'(LOW_MASK(32'(fill)));
        e_data = {{W{1'b0}}, carry};
        n_fill = '0;
        n_carry = '0;
        n_state = PASS;
      end
    end else if (in_fire) begin
      if (total >= NL) begin
        emit = 1'b1;
        e_keep = '1;
        e_last = in.last && total == NL;
        n_fill = total - NL;
        n_carry = merged[MW-1:N*W];
        n_state = (in.last && total != NL) ? FLUSH : PASS;
      end else begin
        emit = in.last;
        e_last = 1'b1;
        e_keep = N'(LOW_MASK(32'(total)));
        n_fill = in.last ? '0 : total;
        n_carry = in.last ? '0 : merged[(N-1)*W-1:0];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data <= '0;
      o_keep <= '0;
      o_last <= 1'b0;
      fill <= '0;
      carry <= '0;
      state <= PASS;
    end else begin
      if (emit) begin
        o_valid <= 1'b1;
        o_data <= e_data;
        o_keep <= e_keep;
        o_last <= e_last;
      end else if (out.ready) begin
        o_valid <= 1'b0;
      end
      fill <= n_fill;
      carry <= n_carry;
      state <= n_state;
    end
  end
`ifdef NDATA_COMPACTOR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_elems_in <= '0;
      stat_elems_out <= '0;
      stat_streams <= '0;
    end else begin
      if (in_fire) stat_elems_in <= SAT_ADD32(stat_elems_in, 32'(cnt));
      if (o_valid && out.ready) stat_elems_out <= SAT_ADD32(stat_elems_out, POPCOUNT(64'(o_keep)));
      if (o_valid && out.ready && o_last) stat_streams <= SAT_ADD32(stat_streams, 32'd1);
    end
  end
`endif
endmodule

// File: tb/tb_ndata_compactor.sv
// tb_ndata_compactor: randomized and directed checks of ndata_compactor against a queue-based element model
module tb_ndata_compactor;
  import libstf::*;
  localparam int N = 4;
  localparam int W = 64;
  localparam int DW = N*W;
  typedef struct {
    logic [DW-1:0] data;
    logic [N-1:0] keep;
    logic last;
    int cyc;
  } beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ndata_i #(.NUM_ELEMENTS(N), .DATA_WIDTH(W)) in_if ();
  ndata_i #(.NUM_ELEMENTS(N), .DATA_WIDTH(W)) out_if ();
  ndata_compactor #(.NUM_ELEMENTS(N), .DATA_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in(in_if),
    .out(out_if)
  );
  beat_t exp_q[$];
  beat_t log_q[$];
  data64_t elem_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rdy_mode = 0;
  logic seen_in_ready;
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask
  function automatic logic [DW-1:0] ln(input data64_t a, input data64_t b, input data64_t c, input data64_t d);
    return {d, c, b, a};
  endfunction
  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = {$urandom, $urandom};
    return d;
  endfunction
  task automatic model_accept(input logic [DW-1:0] d, input logic [N-1:0] k, input logic l);
    beat_t b;
    for (int i = 0; i < N; i++) if (k[i]) elem_q.push_back(d[i*W +: W]);
    while (elem_q.size() > N || (elem_q.size() == N && !l)) begin
      b.data = '0;
      for (int i = 0; i < N; i++) b.data[i*W +: W] = elem_q.pop_front();
      b.keep = '1;
      b.last = 1'b0;
      b.cyc = 0;
      exp_q.push_back(b);
    end
    if (l) begin
      b.data = '0;
      b.keep = '0;
      for (int i = 0; elem_q.size() > 0; i++) begin
        b.data[i*W +: W] = elem_q.pop_front();
        b.keep[i] = 1'b1;
      end
      b.last = 1'b1;
      b.cyc = 0;
      exp_q.push_back(b);
    end
  endtask
  task automatic step(input logic v, input logic [N-1:0] k, input logic [DW-1:0] d, input logic l, output bit acc);
    beat_t b;
    bit exp_rdy;
    @(negedge clk);
    cyc++;
    in_if.valid = v;
    in_if.keep = k;
    in_if.data = d;
    in_if.last = l;
    out_if.ready = rdy_mode == 1 ? 1'($urandom_range(0, 1)) : rdy_mode == 0;
    #1;
    seen_in_ready = in_if.ready;
    chk("out_valid", DW'(out_if.valid), DW'(exp_q.size() != 0));
    exp_rdy = exp_q.size() < 2 && (exp_q.size() == 0 || out_if.ready);
    chk("in_ready", DW'(in_if.ready), DW'(exp_rdy));
    if (out_if.valid && exp_q.size() != 0) begin
      chk("out_data", out_if.data, exp_q[0].data);
      chk("out_keep", DW'(out_if.keep), DW'(exp_q[0].keep));
      chk("out_last", DW'(out_if.last), DW'(exp_q[0].last));
      if (out_if.ready) begin
        b.data = out_if.data;
        b.keep = out_if.keep;
        b.last = out_if.last;
        b.cyc = cyc;
        log_q.push_back(b);
        void'(exp_q.pop_front());
      end
    end
    acc = v && in_if.ready;
    if (acc) model_accept(d, k, l);
  endtask
  task automatic send(input logic [N-1:0] k, input logic [DW-1:0] d, input logic l);
    bit acc;
    int g = 0;
    do begin
      step(1'b1, k, d, l, acc);
      g++;
    end while (!acc && g < 100);
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got not accepted expected accepted");
    end
  endtask
  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, '0, '0, 1'b0, acc);
  endtask
  task automatic drain();
    bit acc;
    int g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      step(1'b0, '0, '0, 1'b0, acc);
      g++;
    end
    chk("drain_empty", DW'(exp_q.size()), DW'(0));
    idle(1);
  endtask
  localparam data64_t J = 64'hDEAD_BEEF_0BAD_F00D;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    in_if.valid = 1'b0;
    in_if.keep = '0;
    in_if.data = '0;
    in_if.last = 1'b0;
    out_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", DW'(out_if.valid), DW'(0));
    chk("rst_keep", DW'(out_if.keep), DW'(0));
    chk("rst_last", DW'(out_if.last), DW'(0));
    chk("rst_data", out_if.data, DW'(0));
    log_q.delete();
    send(4'b1111, ln(1, 2, 3, 4), 1'b0);
    send(4'b1111, ln(5, 6, 7, 8), 1'b0);
    send(4'b1111, ln(9, 10, 11, 12), 1'b1);
    drain();
    chk("dense_count", DW'(log_q.size()), DW'(3));
    if (log_q.size() == 3) begin
      chk("dense_gap", DW'(log_q[2].cyc - log_q[0].cyc), DW'(2));
      chk("dense_last0", DW'(log_q[1].last), DW'(0));
      chk("dense_last2", DW'(log_q[2].last), DW'(1));
      chk("dense_data2", log_q[2].data, ln(9, 10, 11, 12));
    end
    log_q.delete();
    send(4'b0101, ln(64'hA, J, 64'hB, J), 1'b0);
    send(4'b1110, ln(J, 64'hC, 64'hD, 64'hE), 1'b0);
    send(4'b0001, ln(64'hF, J, J, J), 1'b1);
    drain();
    chk("carry_count", DW'(log_q.size()), DW'(2));
    if (log_q.size() == 2) begin
      chk("carry_data0", log_q[0].data, ln(64'hA, 64'hB, 64'hC, 64'hD));
      chk("carry_keep0", DW'(log_q[0].keep), DW'(4'b1111));
      chk("carry_data1", log_q[1].data, ln(64'hE, 64'hF, 0, 0));
      chk("carry_keep1", DW'(log_q[1].keep), DW'(4'b0011));
      chk("carry_last1", DW'(log_q[1].last), DW'(1));
    end
    log_q.delete();
    send(4'b0111, ln(64'h10, 64'h11, 64'h12, J), 1'b0);
    send(4'b1111, ln(64'h13, 64'h14, 64'h15, 64'h16), 1'b1);
    idle(1);
    chk("flush_in_ready", DW'(seen_in_ready), DW'(0));
    drain();
    chk("flush_count", DW'(log_q.size()), DW'(2));
    if (log_q.size() == 2) begin
      chk("flush_data0", log_q[0].data, ln(64'h10, 64'h11, 64'h12, 64'h13));
      chk("flush_last0", DW'(log_q[0].last), DW'(0));
      chk("flush_data1", log_q[1].data, ln(64'h14, 64'h15, 64'h16, 0));
      chk("flush_keep1", DW'(log_q[1].keep), DW'(4'b0111));
    end
    log_q.delete();
    send(4'b0000, ln(J, J, J, J), 1'b1);
    send(4'b1001, ln(64'h20, J, J, 64'h21), 1'b0);
    send(4'b0000, ln(J, J, J, J), 1'b1);
    drain();
    chk("empty_count", DW'(log_q.size()), DW'(2));
    if (log_q.size() == 2) begin
      chk("empty_keep0", DW'(log_q[0].keep), DW'(0));
      chk("empty_last0", DW'(log_q[0].last), DW'(1));
      chk("empty_data0", log_q[0].data, DW'(0));
      chk("empty_data1", log_q[1].data, ln(64'h20, 64'h21, 0, 0));
      chk("empty_keep1", DW'(log_q[1].keep), DW'(4'b0011));
    end
    rdy_mode = 1;
    for (int n = 0; n < 200; n++) begin
      send(4'($urandom_range(0, 15)), rnd_data(), n == 199 || $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rdy_mode = 0;
    drain();
    chk("rand_elems_left", DW'(elem_q.size()), DW'(0));
    log_q.delete();
    send(4'b0011, ln(64'h30, 64'h31, J, J), 1'b0);
    send(4'b1111, ln(64'h32, 64'h33, 64'h34, 64'h35), 1'b0);
    rdy_mode = 2;
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    elem_q.delete();
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    #1;
    chk("midrst_valid", DW'(out_if.valid), DW'(0));
    log_q.delete();
    send(4'b0010, ln(J, 64'h40, J, J), 1'b1);
    drain();
    chk("midrst_count", DW'(log_q.size()), DW'(1));
    if (log_q.size() == 1) begin
      chk("midrst_data", log_q[0].data, ln(64'h40, 0, 0, 0));
      chk("midrst_keep", DW'(log_q[0].keep), DW'(4'b0001));
      chk("midrst_last", DW'(log_q[0].last), DW'(1));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
